// File: rtl/mul_arb.sv
// mul_arb: two-requester arbiter sharing one 6x6 array multiplier, registered response.
// Define MUL_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module mul_arb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [5:0]       req0_a,
    input  logic [5:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [5:0]       req1_a,
    input  logic [5:0]       req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [11:0]      rsp_product,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t      state, state_nxt;
    logic [5:0]  op_a, op_b;
    logic        op_id;
    logic        grant;
    logic        accept;
    logic [11:0] prod;
`ifdef MUL_ARB_FIXED_PRIO_EN
    assign grant = req1_valid & ~req0_valid;
`else
    logic last_grant;
    // grant=1 selects requester 1; on a tie the side not served last wins
    assign grant = req1_valid & (~req0_valid | ~last_grant);
`endif
    assign rsp_valid = state == RESP;
    assign accept    = req0_ready | req1_ready;
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            req0_ready = req0_valid & ~grant;
            req1_ready = grant;
        end
        state_nxt = (state == IDLE) ? ((req0_valid | req1_valid) ? CALC : IDLE) :
                    (state == CALC) ? RESP :
                    (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= 1'b0;
            op_count    <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a  <= grant ? req1_a : req0_a;
                op_b  <= grant ? req1_b : req0_b;
                op_id <= grant;
`ifndef MUL_ARB_FIXED_PRIO_EN
                last_grant <= grant;
`endif
            end
            if (state == CALC) begin
                rsp_product <= prod;
                rsp_id      <= op_id;
            end
            if (rsp_valid && rsp_ready)
                op_count <= op_count + 1'b1;
        end
    end
    Bin_Mul u_mul (.a(op_a), .b(op_b), .p(prod));
endmodule

// Bin_Mul: 6x6 unsigned combinational array multiplier, one shifted partial product per row.
module Bin_Mul (
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic [11:0] p
);
    logic [11:0] s [0:6];
    assign s[0] = '0;
    for (genvar i = 0; i < 6; i++) begin : g_row
        assign s[i+1] = s[i] + ({6'b0, a & {6{b[i]}}} << i);
    end
    assign p = s[6];
endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: directed, table-driven checks of mul_arb arbitration, latency, backpressure and counting.
module tb_mul_arb;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [5:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [11:0] rsp_product;
    logic [7:0]  op_count;
    logic        r0_2, r1_2, rv_2, ri_2;
    logic [11:0] rp_2;
    logic [1:0]  oc_2;
    int          checks = 0, errors = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    mul_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .op_count(op_count)
    );

    mul_arb #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_2),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_2),
        .rsp_valid(rv_2), .rsp_product(rp_2), .rsp_id(ri_2),
        .rsp_ready(rsp_ready), .op_count(oc_2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic do_op(input bit rq, input logic [5:0] a, input logic [5:0] b, input logic [11:0] p);
        if (rq) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        chk("ready_granted", rq ? req1_ready : req0_ready, 1);
        chk("ready_other", rq ? req0_ready : req1_ready, 0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("calc_no_valid", rsp_valid, 0);
        tick;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_product", rsp_product, p);
        chk("rsp_id", rsp_id, rq);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("op_count", op_count, exp_cnt % 256);
        chk("rsp_drop", rsp_valid, 0);
    endtask

    typedef struct {
        bit          rq;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] p;
    } vec_t;

    vec_t        vecs[6];
    logic        ids[3];
    logic [11:0] prods[3];
    logic        exp_ids[3];
    logic [11:0] exp_prods[3];
    int          n;
    bit          both_seen;
    int          seq2[5];

    initial begin
        vecs[0] = '{0, 63, 63, 3969};
        vecs[1] = '{1, 0, 63, 0};
        vecs[2] = '{1, 63, 1, 63};
        vecs[3] = '{0, 7, 9, 63};
        vecs[4] = '{1, 33, 2, 66};
        vecs[5] = '{0, 0, 0, 0};
        seq2 = '{1, 2, 3, 0, 1};
`ifdef MUL_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0};
        exp_prods = '{35, 35, 35};
`else
        exp_ids = '{0, 1, 0};
        exp_prods = '{35, 99, 35};
`endif

        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_product", rsp_product, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_count", op_count, 0);
        do_rst;

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].p);

        do_rst;
        req0_a = 5; req0_b = 7; req1_a = 9; req1_b = 11;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        both_seen = 1'b0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            tick;
            if (req0_ready && req1_ready) both_seen = 1'b1;
            if (rsp_valid) begin
                ids[n] = rsp_id;
                prods[n] = rsp_product;
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        chk("rr_resp_count", n, 3);
        chk("rr_both_ready", both_seen, 0);
        for (int i = 0; i < n; i++) begin
            chk("rr_id", ids[i], exp_ids[i]);
            chk("rr_product", prods[i], exp_prods[i]);
        end

        do_rst;
        req0_valid = 1'b1; req0_a = 3; req0_b = 4;
        tick;
        req0_valid = 1'b0;
        tick;
        req1_valid = 1'b1; req1_a = 1; req1_b = 1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_product", rsp_product, 12);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready", req0_ready | req1_ready, 0);
            chk("bp_count", op_count, 0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        req1_valid = 1'b0;
        chk("bp_release_count", op_count, 1);
        tick;
        chk("bp_count_single", op_count, 1);
        exp_cnt = 1;

        req0_valid = 1'b1; req0_a = 12; req0_b = 10;
        tick;
        req0_valid = 1'b0; req0_a = 0; req0_b = 0;
        tick;
        chk("late_op_product", rsp_product, 120);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("late_op_count", op_count, 2);

        do_rst;
        req0_valid = 1'b1; req0_a = 2; req0_b = 3;
        tick;
        rst = 1'b1;
        tick;
        chk("abort_ready0", req0_ready, 0);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_count", op_count, 0);
        rst = 1'b0;
        req0_valid = 1'b0;
        tick;
        chk("abort_no_rsp", rsp_valid, 0);
        tick;
        chk("abort_no_rsp2", rsp_valid, 0);
        exp_cnt = 0;
        do_op(0, 2, 3, 6);

        do_rst;
        for (int k = 0; k < 5; k++) begin
            do_op(0, 1, 1, 1);
            chk("cnt2", oc_2, seq2[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
